// File: rtl/shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_serializer
//  Description : Parallel-to-serial shift transmitter. Takes a W-bit word on
//                a valid/ready load handshake and shifts it out one bit per
//                accepted output beat, MSB-first or LSB-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_serializer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] i,
  input  logic         l,
  input  logic         r,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         last,
  output logic         busy
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic            dir_q, dir_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            w_in_shift;
  logic            w_last;
  logic            w_beat;
  logic            w_accept;
  logic            w_dir;

  // Outputs are decoded from registers only; load_ready also looks at
  // sout_ready so a new word can slide in on the final beat with no bubble.
  assign w_in_shift = (state_q == ST_SHIFT);
  assign w_last     = w_in_shift && (cnt_q == '0);
  assign w_beat     = w_in_shift && sout_ready;
  assign w_accept   = load_valid && load_ready;

  assign sout_valid = w_in_shift;
  assign busy       = w_in_shift;
  assign last       = w_last;
  assign sout       = w_in_shift & (dir_q ? sr_q[W-1] : sr_q[0]);
  assign load_ready = nrst & (~w_in_shift | (w_last & sout_ready));

  // Direction decode: l=1 selects MSB-first and overrides r; with l=0 both
  // values of r select LSB-first, so the r term can never set the flag.
  assign w_dir = l & ~(~l & r);

  // Next-state logic: load accept has priority over the last-beat return to
  // IDLE; a non-last beat shifts with zero fill and counts down.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (w_accept) begin
      state_d = ST_SHIFT;
      sr_d    = i;
      dir_d   = w_dir;
      cnt_d   = CW'(W - 1);
    end else if (w_beat) begin
      if (w_last) begin
        state_d = ST_IDLE;
        sr_d    = '0;
        dir_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        sr_d  = dir_q ? {sr_q[W-2:0], 1'b0} : {1'b0, sr_q[W-1:1]};
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // State register with synchronous active-low reset that discards any word.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_serializer
//  Description : Directed self-checking bench for shift_serializer with an
//                expected-bit scoreboard filled at load time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_serializer;

  localparam int W = 4;

  logic         clk;
  logic         nrst;
  logic [W-1:0] i;
  logic         l;
  logic         r;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         last;
  logic         busy;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   n_total;
  int   n_pass;
  int   n_fail;

  shift_serializer #(.W(W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .i          (i),
    .l          (l),
    .r          (r),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .last       (last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected serial stream of one word; l=1 means MSB-first.
  task automatic push_word(input logic [W-1:0] w, input logic msb);
    exp_t e;
    for (int k = 0; k < W; k++) begin
      e.b    = msb ? w[W-1-k] : w[k];
      e.last = (k == W - 1);
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word, confirm it is taken at the next edge, then scramble the
  // word inputs to show they are ignored mid-word.
  task automatic load_word(input logic [W-1:0] w, input logic ll, input logic rr);
    i          = w;
    l          = ll;
    r          = rr;
    load_valid = 1'b1;
    @(negedge clk);
    chk("load_ready_at_load", load_ready, 1);
    push_word(w, ll);
    step();
    load_valid = 1'b0;
    i          = W'($urandom);
    l          = 1'($urandom);
    r          = 1'($urandom);
  endtask

  // n cycles in SHIFT with sout_ready=rdy; pops the scoreboard on beats and
  // checks the held bit on stalls.
  task automatic run_beats(input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      sout_ready = rdy;
      @(negedge clk);
      chk("sout_valid", sout_valid, 1);
      chk("busy", busy, 1);
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        chk("sout", sout, sb[0].b);
        chk("last", last, sb[0].last);
        chk("load_ready_in_shift", load_ready, sb[0].last & rdy);
        if (rdy) void'(sb.pop_front());
      end
      step();
    end
  endtask

  task automatic idle_check(input string tag);
    sout_ready = 1'($urandom);
    @(negedge clk);
    chk({tag, "_sout_valid"}, sout_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_sout"}, sout, 0);
    chk({tag, "_load_ready"}, load_ready, 1);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    step();
  endtask

  initial begin
    n_total    = 0;
    n_pass     = 0;
    n_fail     = 0;
    nrst       = 1'b0;
    i          = 4'b1010;
    l          = 1'b0;
    r          = 1'b0;
    load_valid = 1'b1;
    sout_ready = 1'b0;

    // Reset held for two edges with load_valid high: nothing is accepted.
    step();
    @(negedge clk);
    chk("reset_load_ready", load_ready, 0);
    chk("reset_busy", busy, 0);
    step();
    nrst       = 1'b1;
    load_valid = 1'b0;
    idle_check("after_reset");

    // MSB-first 1011.
    sout_ready = 1'b1;
    load_word(4'b1011, 1'b1, 1'b0);
    run_beats(4, 1'b1);
    idle_check("msb_done");

    // LSB-first: l=r=0, l=0 r=1, then l=1 r=1 (l wins).
    load_word(4'b1011, 1'b0, 1'b0);
    run_beats(4, 1'b1);
    idle_check("lsb00_done");
    load_word(4'b1011, 1'b0, 1'b1);
    run_beats(4, 1'b1);
    idle_check("lsb01_done");
    load_word(4'b1011, 1'b1, 1'b1);
    run_beats(4, 1'b1);
    idle_check("lwins_done");

    // Stall three cycles on the first bit of 0110 MSB-first.
    load_word(4'b0110, 1'b1, 1'b0);
    run_beats(3, 1'b0);
    run_beats(4, 1'b1);
    idle_check("stall_done");

    // Back-to-back: 1000 then 0001, second held valid until the last beat.
    sout_ready = 1'b1;
    load_word(4'b1000, 1'b1, 1'b0);
    i          = 4'b0001;
    l          = 1'b1;
    r          = 1'b0;
    load_valid = 1'b1;
    run_beats(4, 1'b1);
    push_word(4'b0001, 1'b1);
    load_valid = 1'b0;
    run_beats(4, 1'b1);
    idle_check("b2b_done");

    // Reset in the middle of 1111, with a competing load that must lose.
    load_word(4'b1111, 1'b1, 1'b0);
    run_beats(2, 1'b1);
    nrst       = 1'b0;
    load_valid = 1'b1;
    i          = 4'b1010;
    @(negedge clk);
    chk("midreset_load_ready", load_ready, 0);
    step();
    nrst       = 1'b1;
    load_valid = 1'b0;
    sb.delete();
    idle_check("midreset");
    sout_ready = 1'b1;
    load_word(4'b0101, 1'b0, 1'b0);
    run_beats(4, 1'b1);
    idle_check("post_reset_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_serializer.md
# shift_serializer

Parallel-to-serial shift transmitter for the lab datapath. It accepts a W-bit word over a valid/ready load handshake. It then shifts the word out one bit per accepted output beat, either MSB-first (left shift, zero fill at bit 0) or LSB-first (right shift, zero fill at MSB). It is the sequential counterpart of the combinational 1-bit left/right shifter: it applies that shift repeatedly under FSM control and emits the bit that falls off the end.

## Interface
- W, default 4: word width, ≥2.
- clk, input, 1: single clock; all state changes on its rising edge.
- nrst, input, 1: reset; synchronous, active-low.
- i, input, W: parallel word to transmit; sampled on load accept.
- l, input, 1: sampled on load accept; 1 selects MSB-first (left shift).
- r, input, 1: sampled on load accept; 1 with l=0 selects LSB-first (right shift). l=r=0 also selects LSB-first. l=1 overrides r.
- load_valid, input, 1: word on i/l/r is valid.
- load_ready, output, 1: block can accept a word this cycle.
- sout, output, 1: current serial bit.
- sout_valid, output, 1: sout holds a valid bit.
- sout_ready, input, 1: consumer takes sout this cycle.
- last, output, 1: current sout is the final bit of the word.
- busy, output, 1: word in flight (state SHIFT).

## Operation
- States:
  - IDLE: no word held.
  - SHIFT: word held in shift register `sr` (W bits), with direction flag `dir` and bit counter `cnt` (width clog2(W)+1).
- load_ready = (state==IDLE) || (state==SHIFT && last && sout_ready). It is forced 0 while nrst=0.
- Load accept is load_valid && load_ready at a rising edge. On accept:
  - sr ← i; dir ← l; cnt ← W−1; state ← SHIFT.
- In SHIFT:
  - sout_valid=1.
  - sout = sr[W−1] if dir=1, else sr[0].
  - last = (cnt==0).
- Beat is sout_valid && sout_ready. On a beat that is not the last bit:
  - dir=1: sr ← {sr[W−2:0],1'b0}.
  - dir=0: sr ← {1'b0,sr[W−1:1]}.
  - cnt ← cnt−1.
- On a beat with last=1:
  - If load_valid in the same cycle, accept the new word (load accept has priority) and stay in SHIFT with no bubble.
  - Otherwise state ← IDLE.
- sout_ready=0 in SHIFT: hold sr, cnt, sout and last unchanged (stall).
- In IDLE: sout_valid=0, sout=0, last=0, busy=0. sout_ready is ignored.
- i, l and r are ignored except on load accept; changes mid-word have no effect.
- load_valid while SHIFT and not on the last beat: not accepted (load_ready=0). The producer holds the word.

## Timing
- Reset (nrst=0 at an edge) applies from any state, including mid-word. The in-flight word is discarded. After that edge:
  - state=IDLE, sr=0, cnt=0, dir=0.
  - sout=0, sout_valid=0, last=0, busy=0.
  - load_ready=1 from the first cycle with nrst=1.
- A load accepted at edge N gives first bit valid on sout from edge N (i.e. in cycle N+1). Latency is 1 cycle.
- With sout_ready held 1: bits k=0..W−1 appear on consecutive cycles N+1..N+W. last=1 in cycle N+W.
- Back-to-back: a next word accepted at edge N+W gives its first bit in cycle N+W+1. Sustained throughput is 1 bit/cycle with no idle gaps.
- All outputs are registered or decoded from registers only, except load_ready, which is combinational on sout_ready.
- nrst=0 together with load_valid=1: reset wins; no word is accepted.

## Test plan
- Reset then idle: hold nrst=0 for 2 cycles, release. Required: sout_valid=0, busy=0, load_ready=1, sout=0, last=0.
- MSB-first, W=4: load i=4'b1011, l=1, r=0, sout_ready=1. Required: sout=1,0,1,1 on cycles 1-4 after accept; last=1 only on cycle 4; back to IDLE on cycle 5.
- LSB-first with l=r=0 and with l=0, r=1: load i=4'b1011. Required: sout=1,1,0,1. With l=1, r=1: sout=1,0,1,1 (l wins).
- Stall: load 4'b0110 MSB-first, drop sout_ready for 3 cycles after the first bit. Required: sout holds 0, cnt is frozen, then 1,1,0 follow. The total word is exactly 4 beats.
- Back-to-back: keep load_valid=1 with 4'b1000 then 4'b0001, both MSB-first. Required: the second word is accepted on the last-beat cycle of the first. The stream is 1,0,0,0,0,0,0,1 with no gap. last pulses on bits 4 and 8.
- Mid-word reset: load 4'b1111, assert nrst=0 after bit 2. Required: the next cycle shows sout_valid=0 and load_ready=1 after release. The next load of 4'b0101 LSB-first gives 1,0,1,0 with no residue of the old word.
